alu_issue_ctrl: RTL and testbench



---
 rtl/alu_issue_ctrl.sv | 168 ++++++++++++++++
 tb/tb_alu_issue_ctrl.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_ctrl.sv
// ============================================================================
// Module   : alu_issue_ctrl
// Brief    : Valid/ready issue stage in front of the 4-bit combinational ALU.
//            Registers operands onto the ALU, captures its result one cycle
//            later, derives zero/error flags and traps divide/mod by zero.
//            Optional error counter enabled by defining ALU_ERRCNT_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_issue_ctrl #(
    parameter int WIDTH = 4
`ifdef ALU_ERRCNT_EN
    ,parameter int CNT_W = 8
`endif
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [2:0]       in_sel,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [2:0]       alu_sel,
    input  logic [WIDTH-1:0] alu_out,
    input  logic             alu_carry,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             out_carry,
    output logic             out_zero,
    output logic             out_err
`ifdef ALU_ERRCNT_EN
    ,output logic [CNT_W-1:0] err_count
`endif
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_EXEC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_DIV = 3'b010;
    localparam logic [2:0] OP_MOD = 3'b011;

    logic [1:0]       state_q,  state_d;
    logic [WIDTH-1:0] alu_a_q,  alu_a_d;
    logic [WIDTH-1:0] alu_b_q,  alu_b_d;
    logic [2:0]       alu_sel_q, alu_sel_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             carry_q,  carry_d;
    logic             zero_q,   zero_d;
    logic             err_q,    err_d;

    logic             w_accept;
    logic             w_div_zero;
    logic             w_carry_op;

    assign w_accept   = (state_q == S_IDLE) && in_valid;
    assign w_div_zero = ((in_sel == OP_DIV) || (in_sel == OP_MOD)) && (in_b == '0);
    // The ALU carry output is only meaningful for add/sub; it is stale otherwise.
    assign w_carry_op = (alu_sel_q == OP_ADD) || (alu_sel_q == OP_SUB);

    always_comb begin
        state_d   = state_q;
        alu_a_d   = alu_a_q;
        alu_b_d   = alu_b_q;
        alu_sel_d = alu_sel_q;
        result_d  = result_q;
        carry_d   = carry_q;
        zero_d    = zero_q;
        err_d     = err_q;

        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    alu_a_d   = in_a;
                    alu_b_d   = in_b;
                    alu_sel_d = in_sel;
                    if (w_div_zero) begin
                        state_d  = S_DONE;
                        result_d = '0;
                        carry_d  = 1'b0;
                        zero_d   = 1'b1;
                        err_d    = 1'b1;
                    end else begin
                        state_d  = S_EXEC;
                    end
                end
            end
            S_EXEC: begin
                result_d = alu_out;
                carry_d  = w_carry_op ? alu_carry : 1'b0;
                zero_d   = (alu_out == '0);
                err_d    = 1'b0;
                state_d  = S_DONE;
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            alu_a_q   <= '0;
            alu_b_q   <= '0;
            alu_sel_q <= '0;
            result_q  <= '0;
            carry_q   <= 1'b0;
            zero_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            alu_a_q   <= alu_a_d;
            alu_b_q   <= alu_b_d;
            alu_sel_q <= alu_sel_d;
            result_q  <= result_d;
            carry_q   <= carry_d;
            zero_q    <= zero_d;
            err_q     <= err_d;
        end
    end

`ifdef ALU_ERRCNT_EN
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

    // Saturating count of trapped divide/modulus-by-zero acceptances.
    always_comb begin
        err_cnt_d = err_cnt_q;
        if (w_accept && w_div_zero && (err_cnt_q != {CNT_W{1'b1}})) begin
            err_cnt_d = err_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_cnt_q <= '0;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end

    assign err_count = err_cnt_q;
`endif

    assign in_ready   = (state_q == S_IDLE);
    assign out_valid  = (state_q == S_DONE);
    assign alu_a      = alu_a_q;
    assign alu_b      = alu_b_q;
    assign alu_sel    = alu_sel_q;
    assign out_result = result_q;
    assign out_carry  = carry_q;
    assign out_zero   = zero_q;
    assign out_err    = err_q;

endmodule

`default_nettype wire

// File: tb/tb_alu_issue_ctrl.sv
// ============================================================================
// Module   : tb_alu_issue_ctrl
// Brief    : Self-checking bench for alu_issue_ctrl with a behavioural ALU
//            stand-in; err_count checks compiled in with ALU_ERRCNT_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_issue_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] in_a;
    logic [3:0] in_b;
    logic [2:0] in_sel;
    logic [3:0] alu_a;
    logic [3:0] alu_b;
    logic [2:0] alu_sel;
    logic [3:0] alu_out;
    logic       alu_carry;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] out_result;
    logic       out_carry;
    logic       out_zero;
    logic       out_err;
`ifdef ALU_ERRCNT_EN
    logic [7:0] err_count;
`endif

    int tests_run    = 0;
    int tests_failed = 0;
    int exp_errcnt   = 0;

    always #5 clk = ~clk;

    alu_issue_ctrl #(.WIDTH(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_sel     (in_sel),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_sel    (alu_sel),
        .alu_out    (alu_out),
        .alu_carry  (alu_carry),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_carry  (out_carry),
        .out_zero   (out_zero),
        .out_err    (out_err)
`ifdef ALU_ERRCNT_EN
        ,.err_count (err_count)
`endif
    );

    // ALU stand-in; carry is forced high for logic/div opcodes so it must be masked.
    logic [4:0] alu_tmp;
    always_comb begin
        alu_tmp   = '0;
        alu_out   = '0;
        alu_carry = 1'b1;
        case (alu_sel)
            3'b000: begin alu_tmp = {1'b0, alu_a} + {1'b0, alu_b}; alu_out = alu_tmp[3:0]; alu_carry = alu_tmp[4]; end
            3'b001: begin alu_tmp = {1'b0, alu_a} - {1'b0, alu_b}; alu_out = alu_tmp[3:0]; alu_carry = alu_tmp[4]; end
            3'b010: alu_out = (alu_b == 4'd0) ? 4'hF : alu_a / alu_b;
            3'b011: alu_out = (alu_b == 4'd0) ? 4'hF : alu_a % alu_b;
            3'b100: alu_out = alu_a | alu_b;
            3'b101: alu_out = alu_a & alu_b;
            3'b110: alu_out = alu_a ^ alu_b;
            default: alu_out = ~alu_a;
        endcase
    end

    // Expected outcome from integer arithmetic; lat = extra cycles to out_valid.
    function automatic void ref_model(input int a, input int b, input int sel,
                                      output int r, output int c, output int e, output int lat);
        r = 0; c = 0; e = 0; lat = 1;
        case (sel)
            0: begin r = (a + b) % 16; c = (a + b > 15) ? 1 : 0; end
            1: begin r = (a - b + 16) % 16; c = (a < b) ? 1 : 0; end
            2: if (b == 0) begin e = 1; lat = 0; end else r = a / b;
            3: if (b == 0) begin e = 1; lat = 0; end else r = a % b;
            4: r = a | b;
            5: r = a & b;
            6: r = a ^ b;
            default: r = 15 - a;
        endcase
    endfunction

    // Present a transaction in IDLE; returns at the negedge after the accepting edge.
    task automatic accept(input logic [3:0] a, input logic [3:0] b, input logic [2:0] sel);
        in_a = a; in_b = b; in_sel = sel; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        if (sel[2:1] == 2'b01 && b == 4'd0 && exp_errcnt < 255) exp_errcnt++;
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_a = '0; in_b = '0; in_sel = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        exp_errcnt = 0;
        @(negedge clk);
        tests_run++; if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
        tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
        tests_run++; if ({alu_a, alu_b, alu_sel} !== 11'd0) begin tests_failed++; $display("FAIL reset_alu_regs got %h %h %h exp 0", alu_a, alu_b, alu_sel); end
        tests_run++; if ({out_result, out_carry, out_zero, out_err} !== 7'd0) begin tests_failed++; $display("FAIL reset_outputs got %h %b %b %b exp 0", out_result, out_carry, out_zero, out_err); end
`ifdef ALU_ERRCNT_EN
        tests_run++; if (err_count !== 8'd0) begin tests_failed++; $display("FAIL reset_err_count got %0d exp 0", err_count); end
`endif
    endtask

    task automatic test_add_overflow();
        accept(4'd7, 4'd9, 3'b000);
        tests_run++; if (out_valid !== 1'b0 || in_ready !== 1'b0) begin tests_failed++; $display("FAIL add_exec_state got valid=%b ready=%b exp 0 0", out_valid, in_ready); end
        tests_run++; if ({alu_a, alu_b, alu_sel} !== {4'd7, 4'd9, 3'b000}) begin tests_failed++; $display("FAIL add_alu_regs got %h %h %h exp 7 9 0", alu_a, alu_b, alu_sel); end
        @(negedge clk);
        tests_run++; if (out_valid !== 1'b1) begin tests_failed++; $display("FAIL add_latency got valid=%b exp 1", out_valid); end
        tests_run++; if ({out_result, out_carry, out_zero, out_err} !== {4'd0, 1'b1, 1'b1, 1'b0}) begin tests_failed++; $display("FAIL add_overflow got r=%h c=%b z=%b e=%b exp r=0 c=1 z=1 e=0", out_result, out_carry, out_zero, out_err); end
        handshake();
        tests_run++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin tests_failed++; $display("FAIL add_release got valid=%b ready=%b exp 0 1", out_valid, in_ready); end
    endtask

    task automatic test_sub_and_mask();
        accept(4'd3, 4'd5, 3'b001);
        @(negedge clk);
        tests_run++; if ({out_result, out_carry, out_zero} !== {4'b1110, 1'b1, 1'b0}) begin tests_failed++; $display("FAIL sub_borrow got r=%b c=%b z=%b exp r=1110 c=1 z=0", out_result, out_carry, out_zero); end
        handshake();
        accept(4'd12, 4'd10, 3'b100);
        @(negedge clk);
        tests_run++; if ({out_result, out_carry, out_zero} !== {4'b1110, 1'b0, 1'b0}) begin tests_failed++; $display("FAIL or_carry_mask got r=%b c=%b z=%b exp r=1110 c=0 z=0", out_result, out_carry, out_zero); end
        handshake();
    endtask

    task automatic test_div_zero();
        accept(4'd9, 4'd0, 3'b010);
        tests_run++; if (out_valid !== 1'b1) begin tests_failed++; $display("FAIL div0_latency got valid=%b exp 1", out_valid); end
        tests_run++; if ({out_result, out_carry, out_zero, out_err} !== {4'd0, 1'b0, 1'b1, 1'b1}) begin tests_failed++; $display("FAIL div0_flags got r=%h c=%b z=%b e=%b exp r=0 c=0 z=1 e=1", out_result, out_carry, out_zero, out_err); end
        tests_run++; if (alu_sel !== 3'b010) begin tests_failed++; $display("FAIL div0_alu_sel got %b exp 010", alu_sel); end
        @(negedge clk);
        tests_run++; if (out_result !== 4'd0 || out_valid !== 1'b1) begin tests_failed++; $display("FAIL div0_no_capture got r=%h valid=%b exp r=0 valid=1", out_result, out_valid); end
`ifdef ALU_ERRCNT_EN
        tests_run++; if (err_count !== 8'(exp_errcnt)) begin tests_failed++; $display("FAIL div0_err_count got %0d exp %0d", err_count, exp_errcnt); end
`endif
        handshake();
    endtask

    task automatic test_backpressure();
        accept(4'd13, 4'd4, 3'b011);
        @(negedge clk);
        tests_run++; if (out_valid !== 1'b1 || out_result !== 4'd1) begin tests_failed++; $display("FAIL bp_result got valid=%b r=%h exp 1 1", out_valid, out_result); end
        in_a = 4'd2; in_b = 4'd3; in_sel = 3'b000; in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            tests_run++; if (out_valid !== 1'b1 || out_result !== 4'd1 || in_ready !== 1'b0 || alu_a !== 4'd13) begin tests_failed++; $display("FAIL bp_hold cyc%0d got valid=%b r=%h ready=%b alu_a=%h exp 1 1 0 d", i, out_valid, out_result, in_ready, alu_a); end
        end
        in_valid = 1'b0;
        handshake();
        tests_run++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin tests_failed++; $display("FAIL bp_release got valid=%b ready=%b exp 0 1", out_valid, in_ready); end
        @(negedge clk);
        tests_run++; if (out_valid !== 1'b0 || alu_a !== 4'd13) begin tests_failed++; $display("FAIL bp_single got valid=%b alu_a=%h exp 0 d", out_valid, alu_a); end
    endtask

    task automatic test_reset_midop();
        accept(4'd6, 4'd2, 3'b010);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        exp_errcnt = 0;
        tests_run++; if (out_valid !== 1'b0 || out_result !== 4'd0 || in_ready !== 1'b1 || alu_a !== 4'd0) begin tests_failed++; $display("FAIL midop_reset got valid=%b r=%h ready=%b alu_a=%h exp 0 0 1 0", out_valid, out_result, in_ready, alu_a); end
        @(negedge clk);
        tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL midop_no_emit got valid=%b exp 0", out_valid); end
    endtask

    task automatic test_random();
        int r, c, e, lat, k, stall;
        logic [3:0] a, b;
        logic [2:0] sel;
        for (int n = 0; n < 150; n++) begin
            a   = 4'($urandom_range(0, 15));
            b   = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
            sel = 3'($urandom_range(0, 7));
            ref_model(int'(a), int'(b), int'(sel), r, c, e, lat);
            accept(a, b, sel);
            k = 0;
            while (out_valid !== 1'b1 && k < 6) begin @(negedge clk); k++; end
            tests_run++; if (k !== lat) begin tests_failed++; $display("FAIL rnd_latency a=%h b=%h sel=%0d got %0d exp %0d", a, b, sel, k, lat); end
            stall = $urandom_range(0, 3);
            in_a = 4'($urandom); in_b = 4'($urandom); in_sel = 3'($urandom); in_valid = (stall != 0);
            repeat (stall) @(negedge clk);
            in_valid = 1'b0;
            tests_run++; if ({out_result, out_carry, out_zero, out_err} !== {4'(r), 1'(c), (r == 0), 1'(e)}) begin tests_failed++; $display("FAIL rnd_result a=%h b=%h sel=%0d got r=%h c=%b z=%b e=%b exp r=%h c=%0d z=%0d e=%0d", a, b, sel, out_result, out_carry, out_zero, out_err, r, c, (r == 0), e); end
            tests_run++; if ({alu_a, alu_b, alu_sel} !== {a, b, sel}) begin tests_failed++; $display("FAIL rnd_alu_hold got %h %h %h exp %h %h %h", alu_a, alu_b, alu_sel, a, b, sel); end
            handshake();
            tests_run++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin tests_failed++; $display("FAIL rnd_release got valid=%b ready=%b exp 0 1", out_valid, in_ready); end
        end
`ifdef ALU_ERRCNT_EN
        tests_run++; if (err_count !== 8'(exp_errcnt)) begin tests_failed++; $display("FAIL rnd_err_count got %0d exp %0d", err_count, exp_errcnt); end
`endif
    endtask

`ifdef ALU_ERRCNT_EN
    task automatic test_errcnt_saturate();
        for (int n = 0; n < 260; n++) begin
            accept(4'($urandom), 4'd0, 3'($urandom_range(2, 3)));
            handshake();
        end
        tests_run++; if (err_count !== 8'd255 || exp_errcnt != 255) begin tests_failed++; $display("FAIL errcnt_saturate got %0d exp 255", err_count); end
    endtask
`endif

    initial begin
        #2000000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_add_overflow();
        test_sub_and_mask();
        test_div_zero();
        test_backpressure();
        test_reset_midop();
        test_random();
`ifdef ALU_ERRCNT_EN
        test_errcnt_saturate();
`endif
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

`default_nettype wire
